gshare_predictor_param: RTL and testbench

//  Parametrised gshare direction predictor: global history XOR PC indexes a table of saturating counters.

---
 rtl/gshare_predictor_param.sv | 85 ++++++++
 tb/tb_gshare_predictor_param.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor_param.sv
// rtl/gshare_predictor_param.sv - gshare direction predictor with init sweep and mispredict counter
module gshare_predictor_param #(
   parameter int PC_W     = 7,
   parameter int HIST_W   = 7,
   parameter int CTR_W    = 2,
   parameter int INIT_CTR = 1,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              areset_n,
   output logic              init_busy,
   input  logic              predict_valid,
   input  logic [PC_W-1:0]   predict_pc,
   output logic              predict_taken,
   output logic [HIST_W-1:0] predict_history,
   input  logic              train_valid,
   input  logic              train_taken,
   input  logic              train_mispredicted,
   input  logic [HIST_W-1:0] train_history,
   input  logic [PC_W-1:0]   train_pc,
   output logic [CNT_W-1:0]  mispred_count
);
   localparam int DEPTH = 2**HIST_W;

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t            state_q, state_d;
   logic [HIST_W-1:0] sweep_ptr;
   logic [HIST_W-1:0] hist_r;
   logic [HIST_W-1:0] pred_idx, train_idx;
   logic [CTR_W-1:0]  pht [DEPTH];
   logic [CTR_W-1:0]  train_ctr, train_ctr_next;
   logic              ready, recover;

   assign ready           = (state_q == ST_READY);
   assign init_busy       = ~ready;
   assign pred_idx        = hist_r ^ predict_pc[HIST_W-1:0];
   assign train_idx       = train_history ^ train_pc[HIST_W-1:0];
   assign recover         = ready & train_valid & train_mispredicted;
   assign predict_taken   = ready & predict_valid & pht[pred_idx][CTR_W-1];
   assign predict_history = (ready & predict_valid) ? hist_r : '0;
   assign train_ctr       = pht[train_idx];

   always_comb begin
      state_d = state_q;
      if (state_q == ST_INIT && sweep_ptr == '1)
         state_d = ST_READY;
   end

   always_comb begin
      train_ctr_next = train_ctr;
      if (train_taken && train_ctr != '1)
         train_ctr_next = train_ctr + 1'b1;
      else if (!train_taken && train_ctr != '0)
         train_ctr_next = train_ctr - 1'b1;
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q       <= ST_INIT;
         sweep_ptr     <= '0;
         hist_r        <= '0;
         mispred_count <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_INIT)
            sweep_ptr <= sweep_ptr + 1'b1;
         // Recovery from a resolved mispredict overrides the speculative shift.
         if (recover)
            hist_r <= {train_history[HIST_W-2:0], train_taken};
         else if (ready && predict_valid)
            hist_r <= {hist_r[HIST_W-2:0], predict_taken};
         if (recover && mispred_count != '1)
            mispred_count <= mispred_count + 1'b1;
      end
   end

   // Table has no reset so it can map onto SRAM; the sweep provides its initial contents.
   always_ff @(posedge clk) begin
      if (!ready)
         pht[sweep_ptr] <= CTR_W'(INIT_CTR);
      else if (train_valid)
         pht[train_idx] <= train_ctr_next;
   end
endmodule

// File: tb/tb_gshare_predictor_param.sv
// tb/tb_gshare_predictor_param.sv - scoreboard bench for gshare_predictor_param
module tb_gshare_predictor_param;
   logic       clk = 1'b0;
   logic       areset_n;
   logic       init_busy;
   logic       predict_valid;
   logic [6:0] predict_pc;
   logic       predict_taken;
   logic [6:0] predict_history;
   logic       train_valid;
   logic       train_taken;
   logic       train_mispredicted;
   logic [6:0] train_history;
   logic [6:0] train_pc;
   logic [1:0] mispred_count;

   always #5 clk = ~clk;

   gshare_predictor_param #(
      .PC_W(7), .HIST_W(7), .CTR_W(2), .INIT_CTR(1), .CNT_W(2)
   ) dut (
      .clk(clk),
      .areset_n(areset_n),
      .init_busy(init_busy),
      .predict_valid(predict_valid),
      .predict_pc(predict_pc),
      .predict_taken(predict_taken),
      .predict_history(predict_history),
      .train_valid(train_valid),
      .train_taken(train_taken),
      .train_mispredicted(train_mispredicted),
      .train_history(train_history),
      .train_pc(train_pc),
      .mispred_count(mispred_count)
   );

   typedef struct {
      logic       pv;
      logic [6:0] ppc;
      logic       tv;
      logic       tt;
      logic       tm;
      logic [6:0] th;
      logic [6:0] tpc;
      logic       e_taken;
      logic [6:0] e_hist;
      logic [1:0] e_cnt;
   } vec_t;

   typedef struct {
      logic       taken;
      logic [6:0] hist;
      logic [1:0] cnt;
      string      name;
   } exp_t;

   vec_t vecs[$];
   exp_t sbq[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   n_busy;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      predict_valid = 0; predict_pc = 0; train_valid = 0; train_taken = 0;
      train_mispredicted = 0; train_history = 0; train_pc = 0;
   endtask

   // Called just after a posedge; drives one cycle, scoreboard-checks outputs at negedge.
   task automatic step(input string name, input vec_t v);
      exp_t e;
      predict_valid = v.pv; predict_pc = v.ppc; train_valid = v.tv; train_taken = v.tt;
      train_mispredicted = v.tm; train_history = v.th; train_pc = v.tpc;
      sbq.push_back('{v.e_taken, v.e_hist, v.e_cnt, name});
      @(negedge clk);
      e = sbq.pop_front();
      chk({e.name, ".taken"}, predict_taken, e.taken);
      chk({e.name, ".hist"}, predict_history, e.hist);
      chk({e.name, ".cnt"}, mispred_count, e.cnt);
      @(posedge clk); #1;
   endtask

   // Counts negedges with init_busy high after a release; stimulus is idled before READY.
   task automatic count_busy(output int n, input bit probe);
      n = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (!init_busy) break;
         n++;
         if (probe && n == 100) begin
            chk("init_ignore.taken", predict_taken, 0);
            chk("init_ignore.hist", predict_history, 0);
            chk("init_ignore.cnt", mispred_count, 0);
         end
         if (n == 120) drive_idle();
      end
   endtask

   initial begin
      vec_t v;
      //               pv ppc    tv tt tm th     tpc    taken hist  cnt
      vecs.push_back('{0, 7'h00, 1, 1, 0, 7'h00, 7'h05, 0, 7'h00, 2'd0});
      vecs.push_back('{0, 7'h00, 1, 1, 0, 7'h00, 7'h05, 0, 7'h00, 2'd0});
      vecs.push_back('{1, 7'h05, 0, 0, 0, 7'h00, 7'h00, 1, 7'h00, 2'd0});
      vecs.push_back('{0, 7'h00, 1, 1, 0, 7'h00, 7'h05, 0, 7'h00, 2'd0});
      vecs.push_back('{1, 7'h04, 0, 0, 0, 7'h00, 7'h00, 1, 7'h01, 2'd0});
      vecs.push_back('{0, 7'h00, 1, 1, 0, 7'h00, 7'h05, 0, 7'h00, 2'd0});
      vecs.push_back('{0, 7'h00, 1, 1, 0, 7'h00, 7'h05, 0, 7'h00, 2'd0});
      vecs.push_back('{0, 7'h00, 1, 1, 0, 7'h00, 7'h05, 0, 7'h00, 2'd0});
      vecs.push_back('{0, 7'h00, 1, 0, 0, 7'h00, 7'h05, 0, 7'h00, 2'd0});
      vecs.push_back('{0, 7'h00, 1, 0, 0, 7'h00, 7'h05, 0, 7'h00, 2'd0});
      vecs.push_back('{1, 7'h06, 0, 0, 0, 7'h00, 7'h00, 0, 7'h03, 2'd0});
      vecs.push_back('{0, 7'h00, 1, 0, 0, 7'h00, 7'h05, 0, 7'h00, 2'd0});
      vecs.push_back('{0, 7'h00, 1, 0, 0, 7'h00, 7'h05, 0, 7'h00, 2'd0});
      vecs.push_back('{1, 7'h03, 0, 0, 0, 7'h00, 7'h00, 0, 7'h06, 2'd0});
      vecs.push_back('{0, 7'h00, 1, 0, 1, 7'h00, 7'h7F, 0, 7'h00, 2'd0});
      vecs.push_back('{0, 7'h00, 0, 1, 1, 7'h55, 7'h00, 0, 7'h00, 2'd1});
      vecs.push_back('{0, 7'h00, 1, 1, 0, 7'h00, 7'h20, 0, 7'h00, 2'd1});
      vecs.push_back('{0, 7'h00, 1, 1, 0, 7'h00, 7'h20, 0, 7'h00, 2'd1});
      vecs.push_back('{1, 7'h20, 0, 0, 0, 7'h00, 7'h00, 1, 7'h00, 2'd1});
      vecs.push_back('{1, 7'h00, 0, 0, 0, 7'h00, 7'h00, 0, 7'h01, 2'd1});
      vecs.push_back('{1, 7'h22, 0, 0, 0, 7'h00, 7'h00, 1, 7'h02, 2'd1});
      vecs.push_back('{1, 7'h11, 1, 0, 1, 7'h3F, 7'h11, 0, 7'h05, 2'd1});
      vecs.push_back('{1, 7'h5E, 0, 0, 0, 7'h00, 7'h00, 1, 7'h7E, 2'd2});
      vecs.push_back('{1, 7'h74, 1, 1, 0, 7'h00, 7'h09, 0, 7'h7D, 2'd2});
      vecs.push_back('{1, 7'h73, 0, 0, 0, 7'h00, 7'h00, 1, 7'h7A, 2'd2});
      vecs.push_back('{0, 7'h00, 1, 0, 1, 7'h00, 7'h40, 0, 7'h00, 2'd2});
      vecs.push_back('{0, 7'h00, 1, 0, 1, 7'h00, 7'h40, 0, 7'h00, 2'd3});
      vecs.push_back('{0, 7'h00, 1, 0, 1, 7'h00, 7'h40, 0, 7'h00, 2'd3});
      vecs.push_back('{0, 7'h00, 0, 0, 0, 7'h00, 7'h00, 0, 7'h00, 2'd3});

      drive_idle();
      areset_n = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.busy", init_busy, 1);
      chk("reset.cnt", mispred_count, 0);

      predict_valid = 1; predict_pc = 7'h2A; train_valid = 1; train_taken = 1;
      train_mispredicted = 1; train_history = 7'h55; train_pc = 7'h2A;
      @(posedge clk); #1;
      areset_n = 1;
      count_busy(n_busy, 1'b1);
      chk("init_len", n_busy, 128);
      @(posedge clk); #1;

      for (int i = 0; i < 128; i++) begin
         v = '{1, 7'(i), 0, 0, 0, 7'h00, 7'h00, 0, 7'h00, 2'd0};
         step($sformatf("sweep_pc%0d", i), v);
      end

      foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

      #3 areset_n = 0;
      #1;
      chk("ready_reset.busy", init_busy, 1);
      chk("ready_reset.cnt", mispred_count, 0);
      @(posedge clk); #1;
      areset_n = 1;
      repeat (40) @(posedge clk);
      #1;
      chk("mid_init.busy", init_busy, 1);
      #2 areset_n = 0;
      #1;
      chk("init_reset.busy", init_busy, 1);
      @(posedge clk); #1;
      areset_n = 1;
      count_busy(n_busy, 1'b0);
      chk("restart_len", n_busy, 128);
      @(posedge clk); #1;

      step("post_reset_pc20", '{1, 7'h20, 0, 0, 0, 7'h00, 7'h00, 0, 7'h00, 2'd0});
      step("post_reset_pc09", '{1, 7'h09, 0, 0, 0, 7'h00, 7'h00, 0, 7'h00, 2'd0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
